serve_controller: RTL

Game-flow controller for Pong that sits directly downstream of the random number generator. It consumes the two random bits `RanNum[1:0]` to pick serve direction and start height, and it keeps score. It runs the serve countdown and hands a launch request to the ball-motion block through a Launch/BallAck handshake. It owns the IDLE → serve → play → point → serve loop and declares game over.

---
 rtl/serve_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/serve_controller.sv
// serve_controller: Pong game-flow FSM that serves from random bits, runs the
// serve countdown, performs the Launch/BallAck handshake and keeps score.
module serve_controller #(
  parameter int DELAY_CYCLES = 50000000,
  parameter int CNT_W        = 26,
  parameter int MAX_SCORE    = 9,
  parameter int X_CENTER     = 320,
  parameter int Y_CENTER     = 240,
  parameter int Y_OFFSET     = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] RanNum,
  input  logic       Start,
  input  logic       PointScored,
  input  logic       ScoredBy,
  input  logic       BallAck,
  output logic       Launch,
  output logic       DirX,
  output logic       DirY,
  output logic [9:0] StartX,
  output logic [9:0] StartY,
  output logic       InPlay,
  output logic       Waiting,
  output logic       GameOver,
  output logic [3:0] ScoreL,
  output logic [3:0] ScoreR
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] COUNT  = 3'd1;
  localparam logic [2:0] LAUNCH = 3'd2;
  localparam logic [2:0] PLAY   = 3'd3;
  localparam logic [2:0] OVER   = 3'd4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rand_x;
  logic             r_pend_x;
  logic             r_dir_x;
  logic             r_dir_y;
  logic [9:0]       r_start_x;
  logic [9:0]       r_start_y;
  logic [3:0]       r_score_l;
  logic [3:0]       r_score_r;
  logic [3:0]       w_inc_l;
  logic [3:0]       w_inc_r;
  logic             w_win;
  always_comb begin
    w_inc_l = (r_score_l == 4'hF) ? r_score_l : r_score_l + 4'd1;
    w_inc_r = (r_score_r == 4'hF) ? r_score_r : r_score_r + 4'd1;
    w_win   = ScoredBy ? (w_inc_r == 4'(MAX_SCORE)) : (w_inc_l == 4'(MAX_SCORE));
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rand_x  <= 1'b1;
      r_pend_x  <= 1'b0;
      r_dir_x   <= 1'b0;
      r_dir_y   <= 1'b0;
      r_start_x <= 10'(X_CENTER);
      r_start_y <= 10'(Y_CENTER);
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
    end else begin
      case (r_state)
        IDLE, OVER: if (Start) begin
          r_state   <= COUNT;
          r_cnt     <= CNT_LOAD;
          r_rand_x  <= 1'b1;
          r_score_l <= 4'd0;
          r_score_r <= 4'd0;
        end
        COUNT: if (r_cnt == '0) begin
          // Serve parameters are frozen here and held through the handshake.
          r_state   <= LAUNCH;
          r_dir_y   <= RanNum[0];
          r_dir_x   <= r_rand_x ? RanNum[1] : r_pend_x;
          r_start_x <= 10'(X_CENTER);
          r_start_y <= (RanNum[1] ^ RanNum[0]) ? 10'(Y_CENTER + Y_OFFSET) : 10'(Y_CENTER - Y_OFFSET);
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        LAUNCH: if (BallAck) r_state <= PLAY;
        PLAY: if (PointScored) begin
          if (ScoredBy) r_score_r <= w_inc_r;
          else r_score_l <= w_inc_l;
          r_pend_x <= ~ScoredBy;
          r_rand_x <= 1'b0;
          r_cnt    <= CNT_LOAD;
          r_state  <= w_win ? OVER : COUNT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign Launch   = (r_state == LAUNCH);
  assign InPlay   = (r_state == PLAY);
  assign Waiting  = (r_state == COUNT);
  assign GameOver = (r_state == OVER);
  assign DirX     = r_dir_x;
  assign DirY     = r_dir_y;
  assign StartX   = r_start_x;
  assign StartY   = r_start_y;
  assign ScoreL   = r_score_l;
  assign ScoreR   = r_score_r;
endmodule
